// File: rtl/display_pkg.sv
// Shared mode encoding and stored screen images for the display frame mux.
// Images are 16x16; row r is a 16-bit word whose bit c is column c.
package display_pkg;

  typedef enum logic [2:0] {
    MODE_NONE  = 3'd0,
    MODE_GAME  = 3'd1,
    MODE_COVER = 3'd2,
    MODE_START = 3'd3,
    MODE_OVER  = 3'd4,
    MODE_WIN   = 3'd5
  } mode_e;

  localparam int IMG_DIM = 16;

  // Index 0 is the top row, listed first.
  typedef logic [0:IMG_DIM-1][IMG_DIM-1:0] img_t;

  localparam img_t COVER_IMG = {
    16'hffff, 16'hffff, 16'h0003, 16'h0003, 16'h3ffb, 16'h3ffb, 16'h300b, 16'h37eb,
    16'h37eb, 16'h300b, 16'h3ffb, 16'h3ffb, 16'h0003, 16'h0003, 16'hffff, 16'hffff
  };

  localparam img_t START_IMG = {
    16'h0000, 16'h0000, 16'h1c3c, 16'h2242, 16'h2040, 16'h1c3c, 16'h0242, 16'h2242,
    16'h1c3c, 16'h0000, 16'h7ffe, 16'h4002, 16'h4002, 16'h7ffe, 16'h0000, 16'h0000
  };

  localparam img_t OVER_IMG = {
    16'h0000, 16'h0000, 16'h0000, 16'h3c3c, 16'h4242, 16'h4242, 16'h4242, 16'h3c3c,
    16'h0000, 16'h4242, 16'h2424, 16'h1818, 16'h1818, 16'h2424, 16'h4242, 16'h0000
  };

  localparam img_t WIN_IMG = {
    16'h0000, 16'h0000, 16'h4bd2, 16'h4a52, 16'h4a52, 16'h5a5a, 16'h6666, 16'h4242,
    16'h0000, 16'h0ff0, 16'h1008, 16'h2004, 16'h2004, 16'h1008, 16'h0ff0, 16'h0000
  };

  // Rows past the image and non-image modes read as blank.
  function automatic logic [IMG_DIM-1:0] image_row(input mode_e m, input int r);
    logic [IMG_DIM-1:0] row;
    row = '0;
    if (r >= 0 && r < IMG_DIM) begin
      case (m)
        MODE_COVER: row = COVER_IMG[r[3:0]];
        MODE_START: row = START_IMG[r[3:0]];
        MODE_OVER:  row = OVER_IMG[r[3:0]];
        MODE_WIN:   row = WIN_IMG[r[3:0]];
        default:    row = '0;
      endcase
    end
    return row;
  endfunction

endpackage

// File: rtl/display_wipe_ctrl.sv
// Row-wipe sequencer: decides which rows get written on each frame tick.
// Outside a wipe every row is refreshed each tick.
module display_wipe_ctrl
  import display_pkg::*;
#(
  parameter int ROWS        = 16,
  parameter int WIPE_EN     = 1,
  parameter int WIPE_FRAMES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            frame_tick,
  input  logic            commit,
  output logic [ROWS-1:0] row_we,
  output logic            wipe_busy
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int FW = $clog2(WIPE_FRAMES + 1);
  localparam logic [FW-1:0] FC_LAST  = FW'(WIPE_FRAMES - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  logic [RW-1:0] wipe_row;
  logic [FW-1:0] frame_cnt;

  always_comb begin
    row_we = '1;
    if (commit) begin
      if (WIPE_EN != 0) row_we = ROWS'(1);
    end else if (wipe_busy) begin
      row_we = '0;
      if (frame_cnt == FC_LAST) row_we[wipe_row] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wipe_row  <= '0;
      frame_cnt <= '0;
      wipe_busy <= 1'b0;
    end else if (frame_tick) begin
      if (commit) begin
        // A commit mid-wipe restarts the sweep from the top.
        frame_cnt <= '0;
        if (WIPE_EN != 0) begin
          wipe_row  <= RW'(1);
          wipe_busy <= 1'b1;
        end
      end else if (wipe_busy) begin
        if (frame_cnt == FC_LAST) begin
          frame_cnt <= '0;
          if (wipe_row == ROW_LAST) begin
            wipe_row  <= '0;
            wipe_busy <= 1'b0;
          end else begin
            wipe_row <= wipe_row + 1'b1;
          end
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/display_frame_mux.sv
// Selects live game frame or a stored screen for the LED scan driver,
// switching only on frame ticks with optional row wipe and blink.
module display_frame_mux
  import display_pkg::*;
#(
  parameter int ROWS         = 16,
  parameter int COLS         = 16,
  parameter int WIPE_EN      = 1,
  parameter int WIPE_FRAMES  = 2,
  parameter int BLINK_FRAMES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_tick,
  input  logic                 sel_game,
  input  logic                 sel_cover,
  input  logic                 sel_start,
  input  logic                 sel_over,
  input  logic                 sel_win,
  input  logic                 blink_en,
  input  logic [ROWS*COLS-1:0] game_frame,
  output logic [ROWS*COLS-1:0] led_frame,
  output logic [2:0]           cur_mode,
  output logic                 wipe_busy
);

  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [BW-1:0] BC_LAST = BW'(BLINK_FRAMES - 1);

  mode_e                      cur_q;
  mode_e                      req;
  mode_e                      src_mode;
  logic                       commit;
  logic                       blink_act;
  logic                       blank;
  logic [BW-1:0]              blink_cnt;
  logic                       blink_phase;
  logic [ROWS-1:0]            row_we;
  logic [ROWS-1:0][COLS-1:0]  row_src;
  logic [ROWS-1:0][COLS-1:0]  led_q;
  logic [COLS+IMG_DIM-1:0]    img_ext;

  always_comb begin
    req = cur_q;
    if (sel_game)       req = MODE_GAME;
    else if (sel_cover) req = MODE_COVER;
    else if (sel_start) req = MODE_START;
    else if (sel_over)  req = MODE_OVER;
    else if (sel_win)   req = MODE_WIN;
  end

  assign commit    = frame_tick && (req != cur_q);
  // On a commit tick the incoming mode already drives the written rows.
  assign src_mode  = commit ? req : cur_q;
  assign blink_act = blink_en && (cur_q == MODE_OVER || cur_q == MODE_WIN) && !wipe_busy;
  assign blank     = !commit && blink_act && blink_phase;

  display_wipe_ctrl #(
    .ROWS        (ROWS),
    .WIPE_EN     (WIPE_EN),
    .WIPE_FRAMES (WIPE_FRAMES)
  ) u_wipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .commit     (commit),
    .row_we     (row_we),
    .wipe_busy  (wipe_busy)
  );

  // Images are zero-extended/truncated to the matrix width.
  always_comb begin
    row_src = '0;
    img_ext = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (src_mode == MODE_GAME) begin
        row_src[r] = game_frame[r*COLS +: COLS];
      end else begin
        img_ext    = {{COLS{1'b0}}, image_row(src_mode, r)};
        row_src[r] = img_ext[COLS-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q       <= MODE_NONE;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      led_q       <= '0;
    end else if (frame_tick) begin
      if (commit) begin
        cur_q       <= req;
        blink_cnt   <= '0;
        blink_phase <= 1'b0;
      end else if (blink_act) begin
        if (blink_cnt == BC_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end else if (!blink_en) begin
        blink_cnt <= '0;
      end
      for (int r = 0; r < ROWS; r++) begin
        if (row_we[r]) led_q[r] <= blank ? '0 : row_src[r];
      end
    end
  end

  assign led_frame = led_q;
  assign cur_mode  = cur_q;

endmodule

// File: tb/tb_display_frame_mux.sv
// Randomized + directed bench for display_frame_mux, wiped and instant variants
// side by side, checked against a tick-count based reference model.
module tb_display_frame_mux;
  import display_pkg::*;

  localparam int ROWS = 16;
  localparam int COLS = 16;
  localparam int N    = ROWS * COLS;
  localparam int WF   = 2;
  localparam int BF   = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         frame_tick;
  logic         sel_game, sel_cover, sel_start, sel_over, sel_win;
  logic         blink_en;
  logic [N-1:0] game_frame;
  logic [N-1:0] led_w, led_i;
  logic [2:0]   mode_w, mode_i;
  logic         busy_w, busy_i;

  display_frame_mux #(
    .ROWS(ROWS), .COLS(COLS), .WIPE_EN(1), .WIPE_FRAMES(WF), .BLINK_FRAMES(BF)
  ) u_dut_w (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .sel_game(sel_game), .sel_cover(sel_cover), .sel_start(sel_start),
    .sel_over(sel_over), .sel_win(sel_win), .blink_en(blink_en),
    .game_frame(game_frame), .led_frame(led_w), .cur_mode(mode_w), .wipe_busy(busy_w)
  );

  display_frame_mux #(
    .ROWS(ROWS), .COLS(COLS), .WIPE_EN(0), .WIPE_FRAMES(WF), .BLINK_FRAMES(BF)
  ) u_dut_i (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .sel_game(sel_game), .sel_cover(sel_cover), .sel_start(sel_start),
    .sel_over(sel_over), .sel_win(sel_win), .blink_en(blink_en),
    .game_frame(game_frame), .led_frame(led_i), .cur_mode(mode_i), .wipe_busy(busy_i)
  );

  always #5 clk = ~clk;

  // Wipe progress is derived from the tick index of the last commit (tc)
  // rather than from counters: row k lands WF*k ticks after the commit.
  typedef struct {
    int           mode;
    int           tc;
    int           n;
    int           bcnt;
    bit           phase;
    logic [N-1:0] led;
  } model_t;

  model_t mw, mi;
  int     errs = 0;
  int     checks = 0;

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic model_t m_reset();
    model_t s;
    s.mode = 0; s.tc = -1; s.n = 0; s.bcnt = 0; s.phase = 1'b0; s.led = '0;
    return s;
  endfunction

  function automatic bit m_busy(input model_t s, input bit we);
    return we && s.tc >= 0 && (s.n - s.tc) >= 1 && (s.n - s.tc) <= (ROWS-1)*WF;
  endfunction

  function automatic logic [COLS-1:0] m_row(input int m, input int r);
    case (m)
      1:       return game_frame[r*COLS +: COLS];
      2:       return COVER_IMG[r];
      3:       return START_IMG[r];
      4:       return OVER_IMG[r];
      5:       return WIN_IMG[r];
      default: return '0;
    endcase
  endfunction

  function automatic model_t m_step(input model_t s_in, input bit we);
    model_t s;
    int req, e;
    bit busy, act;
    s    = s_in;
    busy = m_busy(s, we);
    act  = blink_en && (s.mode == 4 || s.mode == 5) && !busy;
    req  = s.mode;
    if (sel_win)   req = 5;
    if (sel_over)  req = 4;
    if (sel_start) req = 3;
    if (sel_cover) req = 2;
    if (sel_game)  req = 1;
    if (req != s.mode) begin
      s.mode = req; s.tc = s.n; s.bcnt = 0; s.phase = 1'b0;
      for (int r = 0; r < ROWS; r++)
        if (!we || r == 0) s.led[r*COLS +: COLS] = m_row(req, r);
    end else begin
      if (busy) begin
        e = s.n - s.tc;
        if (e % WF == 0) s.led[(e/WF)*COLS +: COLS] = m_row(s.mode, e / WF);
      end else begin
        for (int r = 0; r < ROWS; r++)
          s.led[r*COLS +: COLS] = (act && s.phase) ? '0 : m_row(s.mode, r);
      end
      if (act) begin
        if (s.bcnt == BF-1) begin s.bcnt = 0; s.phase = !s.phase; end
        else s.bcnt++;
      end else if (!blink_en) begin
        s.bcnt = 0;
      end
    end
    s.n++;
    return s;
  endfunction

  function automatic logic [COLS-1:0] row_of(input logic [N-1:0] f, input int r);
    return f[r*COLS +: COLS];
  endfunction

  function automatic logic [N-1:0] rand_frame();
    logic [N-1:0] f;
    for (int k = 0; k < N/32; k++) f[k*32 +: 32] = $urandom;
    return f;
  endfunction

  task automatic compare_all();
    chk("led_w",  led_w,  mw.led);
    chk("mode_w", mode_w, mw.mode);
    chk("busy_w", busy_w, m_busy(mw, 1'b1));
    chk("led_i",  led_i,  mi.led);
    chk("mode_i", mode_i, mi.mode);
    chk("busy_i", busy_i, 1'b0);
  endtask

  // Called at a negedge: drive, clock, update model, check at next negedge.
  task automatic cyc(input bit tick);
    frame_tick = tick;
    @(posedge clk);
    if (tick && rst_n) begin
      mw = m_step(mw, 1'b1);
      mi = m_step(mi, 1'b0);
    end
    @(negedge clk);
    compare_all();
  endtask

  task automatic ticks(input int n, input int gap);
    repeat (n) begin
      repeat (gap) cyc(1'b0);
      cyc(1'b1);
    end
  endtask

  task automatic set_sel(input bit g, input bit c, input bit s, input bit o, input bit w);
    sel_game = g; sel_cover = c; sel_start = s; sel_over = o; sel_win = w;
  endtask

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; blink_en = 1'b0;
    set_sel(0, 0, 0, 0, 0);
    game_frame = rand_frame();
    mw = m_reset(); mi = m_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // Request without a tick must not change anything.
    set_sel(0, 1, 0, 0, 0);
    repeat (10) cyc(1'b0);
    chk("idle_led", led_i, '0);
    chk("idle_mode", mode_w, 3'd0);
    cyc(1'b1);
    chk("cov_r0", row_of(led_i, 0), 16'hffff);
    chk("cov_r1", row_of(led_i, 1), 16'hffff);
    chk("cov_r2", row_of(led_i, 2), 16'h0003);
    chk("cov_mode", mode_i, 3'd2);
    chk("cov_w_r1_old", row_of(led_w, 1), 16'h0000);
    ticks(30, 1);
    chk("cov_w_done", busy_w, 1'b0);

    // Wipe timing toward START.
    set_sel(0, 0, 1, 0, 0);
    cyc(1'b1);
    chk("st_busy", busy_w, 1'b1);
    ticks(3, 0);
    chk("st_r2_pre", row_of(led_w, 2), 16'h0003);
    ticks(1, 0);
    chk("st_r2", row_of(led_w, 2), 16'h1c3c);
    chk("st_r3_pre", row_of(led_w, 3), 16'h0003);
    ticks(2, 0);
    chk("st_r3", row_of(led_w, 3), 16'h2242);
    ticks(23, 0);
    chk("st_busy_t30", busy_w, 1'b1);
    ticks(1, 0);
    chk("st_busy_t31", busy_w, 1'b0);

    // Priority and live game tracking.
    game_frame[15:0] = 16'h00a5;
    set_sel(1, 1, 0, 0, 0);
    cyc(1'b1);
    chk("game_prio", mode_w, 3'd1);
    ticks(30, 0);
    chk("game_r0", row_of(led_w, 0), 16'h00a5);
    game_frame[15:0] = 16'h1234;
    cyc(1'b1);
    chk("game_track", row_of(led_w, 0), 16'h1234);

    // Blink on OVER once the wipe is done.
    set_sel(0, 0, 0, 1, 0);
    blink_en = 1'b1;
    cyc(1'b1);
    ticks(30, 0);
    for (int k = 0; k < 22; k++) begin
      cyc(1'b1);
      chk("blink_r3", row_of(led_w, 3), ((k / BF) % 2 == 0) ? 16'h3c3c : 16'h0000);
    end
    blink_en = 1'b0;
    cyc(1'b1);
    chk("blink_off", row_of(led_w, 3), 16'h3c3c);

    // Interrupted wipe: START, then WIN at row 5.
    set_sel(0, 0, 1, 0, 0);
    cyc(1'b1);
    ticks(10, 0);
    chk("mid_r5", row_of(led_w, 5), 16'h1c3c);
    set_sel(0, 0, 0, 0, 1);
    cyc(1'b1);
    ticks(4, 0);
    chk("win_r2", row_of(led_w, 2), 16'h4bd2);
    chk("stale_r5", row_of(led_w, 5), 16'h1c3c);
    chk("stale_r6", row_of(led_w, 6), 16'h4242);
    ticks(30, 0);

    // Hold with no request.
    set_sel(0, 0, 0, 0, 0);
    ticks(5, 1);
    chk("hold_mode", mode_w, 3'd5);
    chk("hold_r2", row_of(led_w, 2), 16'h4bd2);

    // Asynchronous reset mid-wipe.
    set_sel(0, 1, 0, 0, 0);
    cyc(1'b1);
    ticks(5, 0);
    chk("pre_rst_busy", busy_w, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_led", led_w, '0);
    chk("arst_busy", busy_w, 1'b0);
    chk("arst_mode", mode_i, 3'd0);
    mw = m_reset(); mi = m_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      set_sel($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
              $urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0,
              $urandom_range(0, 11) == 0);
      if ($urandom_range(0, 19) == 0) blink_en = ~blink_en;
      if ($urandom_range(0, 3) == 0) game_frame = rand_frame();
      cyc($urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
